// File: rtl/rgb2gray_frame_ctrl.sv
// Frame sequencer for the RGB2Gray input stage: gates pixel strobes, tracks col/row, aligns gray valid/done.
// Optional protocol-error detection enabled by defining RGB2GRAY_CTRL_ERR_EN.
module rgb2gray_frame_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIPE_LAT   = 4,
  localparam int COL_W = $clog2(IMG_WIDTH),
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             pixel_valid_i,
  output logic             dp_en_o,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic             gray_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  localparam logic [COL_W-1:0] COL_MAX    = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_MAX    = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [3:0]       DRAIN_LOAD = 4'((PIPE_LAT > 1) ? PIPE_LAT - 2 : 0);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t              state;
  logic [COL_W-1:0]    col_cnt;
  logic [ROW_W-1:0]    row_cnt;
  logic [3:0]          drain_cnt;
  logic [PIPE_LAT-1:0] vchain;

  assign dp_en_o      = (state == RUN) && pixel_valid_i;
  assign col_o        = col_cnt;
  assign row_o        = row_cnt;
  assign gray_valid_o = vchain[PIPE_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      col_cnt   <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
      vchain    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      vchain[0] <= dp_en_o;
      for (int unsigned i = 1; i < PIPE_LAT; i++) vchain[i] <= vchain[i-1];
      case (state)
        IDLE: begin
          if (start_i) begin
            state   <= RUN;
            busy_o  <= 1'b1;
            col_cnt <= '0;
            row_cnt <= '0;
          end
        end
        RUN: begin
          if (pixel_valid_i) begin
            if (col_cnt == COL_MAX) begin
              col_cnt <= '0;
              if (row_cnt == ROW_MAX) begin
                row_cnt <= '0;
                // DRAIN holds PIPE_LAT-1 cycles so DONE lands on the last chain output
                if (PIPE_LAT == 1) begin
                  state  <= DONE;
                  done_o <= 1'b1;
                end else begin
                  state     <= DRAIN;
                  drain_cnt <= DRAIN_LOAD;
                end
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end else begin
              col_cnt <= col_cnt + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RGB2GRAY_CTRL_ERR_EN
  // An accepted start clears the flag; pixel_valid in that same cycle is exempt.
  always_ff @(posedge clk) begin
    if (rst)
      err_o <= 1'b0;
    else if (state == IDLE && start_i)
      err_o <= 1'b0;
    else if ((start_i && busy_o) || (pixel_valid_i && state != RUN))
      err_o <= 1'b1;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rgb2gray_frame_ctrl.sv
// Scoreboard bench: two controllers (PIPE_LAT=4 and PIPE_LAT=1, W=4, H=2) share directed stimulus.
// Stimulus pushes expected accepts/gray events; a negedge monitor pops and compares.
module tb_rgb2gray_frame_ctrl;

  localparam int W = 4;
  localparam int H = 2;
`ifdef RGB2GRAY_CTRL_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  typedef struct {int col; int row;} acc_t;
  typedef struct {int cyc; bit done;} gray_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_i = 1'b0;
  logic       pixel_valid = 1'b0;
  logic       dp_en[2];
  logic [1:0] col[2];
  logic [0:0] row[2];
  logic       gray[2];
  logic       busy[2];
  logic       done[2];
  logic       err[2];

  acc_t  acc_q[2][$];
  gray_t gray_q[2][$];

  int  cyc = 0;
  int  nchk = 0;
  int  nfail = 0;
  int  k = 0;
  bit  running = 1'b0;
  bit  mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rgb2gray_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIPE_LAT(4)) u_lat4 (
    .clk(clk), .rst(rst), .start_i(start_i), .pixel_valid_i(pixel_valid),
    .dp_en_o(dp_en[0]), .col_o(col[0]), .row_o(row[0]), .gray_valid_o(gray[0]),
    .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]));

  rgb2gray_frame_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIPE_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .start_i(start_i), .pixel_valid_i(pixel_valid),
    .dp_en_o(dp_en[1]), .col_o(col[1]), .row_o(row[1]), .gray_valid_o(gray[1]),
    .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]));

  function automatic int lat_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic check(input string nm, input int d, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", nm, d, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic pv);
    pixel_valid = pv;
    if (running && pv) begin
      for (int d = 0; d < 2; d++) begin
        acc_q[d].push_back('{col: k % W, row: k / W});
        gray_q[d].push_back('{cyc: cyc + lat_of(d), done: (k == W*H-1)});
      end
      k++;
      if (k == W*H) running = 1'b0;
    end
    tick();
  endtask

  // pixel_valid is raised in the start cycle to confirm it is ignored there
  task automatic start_frame();
    start_i = 1'b1;
    pixel_valid = 1'b1;
    running = 1'b1;
    k = 0;
    tick();
    start_i = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        int exp_done;
        exp_done = 0;
        if (dp_en[d]) begin
          check("accept_expected", d, int'(acc_q[d].size() != 0), 1);
          if (acc_q[d].size() != 0) begin
            acc_t a;
            a = acc_q[d].pop_front();
            check("col", d, int'(col[d]), a.col);
            check("row", d, int'(row[d]), a.row);
          end
        end
        if (gray[d]) begin
          check("gray_expected", d, int'(gray_q[d].size() != 0), 1);
          if (gray_q[d].size() != 0) begin
            gray_t g;
            g = gray_q[d].pop_front();
            check("gray_cycle", d, cyc, g.cyc);
            exp_done = int'(g.done);
          end
        end
        if (gray_q[d].size() != 0)
          check("gray_late", d, int'(gray_q[d][0].cyc >= cyc), 1);
        check("done", d, int'(done[d]), exp_done);
      end
    end
  end

  initial begin
    int c0;
    tick();
    tick();
    for (int d = 0; d < 2; d++) begin
      check("rst_dp_en", d, int'(dp_en[d]), 0);
      check("rst_gray", d, int'(gray[d]), 0);
      check("rst_busy", d, int'(busy[d]), 0);
      check("rst_done", d, int'(done[d]), 0);
      check("rst_err", d, int'(err[d]), 0);
      check("rst_col", d, int'(col[d]), 0);
      check("rst_row", d, int'(row[d]), 0);
    end
    mon_en = 1'b1;
    rst = 1'b0;
    tick();

    // continuous frame
    c0 = cyc;
    start_frame();
    check("busy_after_start", 0, int'(busy[0]), 1);
    check("busy_after_start", 1, int'(busy[1]), 1);
    for (int i = 0; i < W*H; i++) step(1'b1);
    idle_cycles(3);
    check("busy_done_cycle_rel", 0, cyc - c0, 12);
    check("busy_on_done_cycle", 0, int'(busy[0]), 1);
    idle_cycles(1);
    check("busy_cleared", 0, int'(busy[0]), 0);
    check("busy_cleared", 1, int'(busy[1]), 0);
    check("err_clean", 0, int'(err[0]), 0);
    check("err_clean", 1, int'(err[1]), 0);

    // gapped input
    start_frame();
    for (int i = 0; i < W*H; i++) begin
      step(1'b1);
      step(1'b0);
    end
    idle_cycles(6);
    check("busy_after_gapped", 0, int'(busy[0]), 0);
    check("busy_after_gapped", 1, int'(busy[1]), 0);

    // reset on the 5th accept; pending gray events are discarded
    start_frame();
    for (int i = 0; i < 4; i++) step(1'b1);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    pixel_valid = 1'b0;
    running = 1'b0;
    for (int d = 0; d < 2; d++) begin
      gray_q[d].delete();
      check("busy_after_rst", d, int'(busy[d]), 0);
      check("gray_after_rst", d, int'(gray[d]), 0);
    end
    idle_cycles(6);
    start_frame();
    for (int i = 0; i < W*H; i++) step(1'b1);
    idle_cycles(5);

    // protocol abuse: start during RUN, pixel_valid after last accept
    start_frame();
    for (int i = 0; i < 3; i++) step(1'b1);
    start_i = 1'b1;
    step(1'b1);
    start_i = 1'b0;
    check("err_start_in_run", 0, int'(err[0]), int'(ERR_ON));
    check("err_start_in_run", 1, int'(err[1]), int'(ERR_ON));
    for (int i = 0; i < 4; i++) step(1'b1);
    step(1'b1);
    check("err_pv_drain", 0, int'(err[0]), int'(ERR_ON));
    check("err_pv_done", 1, int'(err[1]), int'(ERR_ON));
    idle_cycles(4);
    check("err_sticky", 0, int'(err[0]), int'(ERR_ON));
    check("err_sticky", 1, int'(err[1]), int'(ERR_ON));
    check("busy_after_abuse", 0, int'(busy[0]), 0);
    start_frame();
    check("err_cleared_by_start", 0, int'(err[0]), 0);
    check("err_cleared_by_start", 1, int'(err[1]), 0);
    for (int i = 0; i < W*H; i++) step(1'b1);
    idle_cycles(6);
    for (int d = 0; d < 2; d++) begin
      check("err_final", d, int'(err[d]), 0);
      check("acc_q_empty", d, acc_q[d].size(), 0);
      check("gray_q_empty", d, gray_q[d].size(), 0);
    end
    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
